// File: rtl/inst_fetch_buf.sv
// Instruction-fetch stage: issues req/gnt/rvalid fetches for the current PC and queues
// returned words with their PCs in a 2-entry buffer feeding the registered ID outputs.
module inst_fetch_buf #(
    parameter int DEPTH          = 2,
    parameter int ADDR_MASK_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        stall_o,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t      state;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] req_pc;
    logic [31:0] buf_pc   [DEPTH];
    logic [31:0] buf_inst [DEPTH];

    logic [2:0]  occupancy;
    logic        room;
    logic        grant;
    logic        push;
    logic        pop;

    // An outstanding access reserves a slot so its returning word always fits.
    assign occupancy = {1'b0, count} + {2'b00, (state != IDLE)};
    assign room      = (occupancy < 3'd2);

    assign inst_req  = ce_i & (state == IDLE) & room & ~flush_i;
    assign grant     = inst_req & inst_gnt;
    assign stall_o   = ce_i & ~grant;
    assign inst_addr = {{ADDR_MASK_BITS{1'b0}}, pc_i[31-ADDR_MASK_BITS:0]};

    assign push = (state == WAIT) & inst_rvalid & ~flush_i;
    assign pop  = ~stall_i & (count != 2'd0);

    // NOTE: buffer storage has no reset; count and the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= req_pc;
            buf_inst[wr_ptr] <= inst_rdata;
        end
    end

    // NOTE: non-blocking assignments so every read below sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            req_pc     <= 32'h0;
            id_pc_o    <= 32'h0;
            id_inst_o  <= 32'h0;
            id_valid_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= WAIT;
                        req_pc <= pc_i;
                    end
                end
                WAIT: begin
                    if (inst_rvalid) begin
                        state <= IDLE;
                    end else if (flush_i) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (inst_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush_i) begin
                count      <= 2'd0;
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                id_valid_o <= 1'b0;
            end else begin
                if (!stall_i) begin
                    id_valid_o <= (count != 2'd0);
                    if (pop) begin
                        id_pc_o   <= buf_pc[rd_ptr];
                        id_inst_o <= buf_inst[rd_ptr];
                        rd_ptr    <= ~rd_ptr;
                    end
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: directed scenarios plus randomized traffic
// compared against a queue-based transaction model of the fetch stage.
module tb_inst_fetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        flush_i;
    logic        stall_i;
    logic        stall_o;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    inst_fetch_buf dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .stall_o    (stall_o),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_gnt   (inst_gnt),
        .inst_rvalid(inst_rvalid),
        .inst_rdata (inst_rdata),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queued words, one outstanding access, and a "doomed" mark for flushed ones.
    entry_t      m_q[$];
    bit          m_busy     = 1'b0;
    bit          m_doomed   = 1'b0;
    logic [31:0] m_req_pc   = 32'h0;
    logic [31:0] m_id_pc    = 32'h0;
    logic [31:0] m_id_inst  = 32'h0;
    bit          m_id_valid = 1'b0;

    // Memory and PC-register behaviour.
    bit          mem_pending  = 1'b0;
    int          mem_delay    = 0;
    logic [31:0] mem_addr     = 32'h0;
    int          mem_lat      = 0;
    bit          rand_lat     = 1'b0;
    bit          stray_rvalid = 1'b0;
    logic [31:0] flush_target = 32'h0;

    bit          exp_req;
    bit          exp_stall;
    logic [31:0] exp_addr;
    logic        obs_req;
    logic        obs_stall;
    logic [31:0] obs_addr;

    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    function automatic logic [31:0] word_of(logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
    endfunction

    // One clock: drive memory response, predict combinational outputs, sample them
    // mid-cycle, then advance the model, memory and PC after the edge.
    task automatic cycle();
        entry_t e;
        bit     ret;
        bit     granted;
        inst_rvalid = (mem_pending && mem_delay == 0) || stray_rvalid;
        inst_rdata  = (mem_pending && mem_delay == 0) ? word_of(mem_addr) : $urandom;
        exp_req   = ce_i && !m_busy && (m_q.size() < 2) && !flush_i;
        exp_stall = ce_i && !(exp_req && inst_gnt);
        exp_addr  = pc_i & 32'h1FFF_FFFF;
        granted   = exp_req && inst_gnt;
        @(negedge clk);
        obs_req   = inst_req;
        obs_stall = stall_o;
        obs_addr  = inst_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_busy      = 1'b0;
            m_doomed    = 1'b0;
            m_req_pc    = 32'h0;
            m_id_pc     = 32'h0;
            m_id_inst   = 32'h0;
            m_id_valid  = 1'b0;
            mem_pending = 1'b0;
        end else begin
            ret = m_busy && inst_rvalid;
            if (flush_i) begin
                m_q.delete();
                m_id_valid = 1'b0;
            end else begin
                if (!stall_i) begin
                    m_id_valid = (m_q.size() != 0);
                    if (m_q.size() != 0) begin
                        e         = m_q.pop_front();
                        m_id_pc   = e.pc;
                        m_id_inst = e.inst;
                    end
                end
                if (ret && !m_doomed) m_q.push_back({m_req_pc, inst_rdata});
            end
            if (ret) begin
                m_busy   = 1'b0;
                m_doomed = 1'b0;
            end else if (m_busy && flush_i) begin
                m_doomed = 1'b1;
            end
            if (mem_pending) begin
                if (mem_delay == 0) mem_pending = 1'b0;
                else mem_delay--;
            end
            if (granted) begin
                m_busy      = 1'b1;
                m_req_pc    = pc_i;
                mem_pending = 1'b1;
                mem_delay   = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                mem_addr    = pc_i;
            end
            if (flush_i) pc_i = flush_target;
            else if (granted) pc_i = pc_i + 32'd4;
        end
    endtask

    // Runs n cycles with fetch enabled up to pc limit, recording everything ID receives.
    task automatic collect(int n, logic [31:0] limit);
        got_pc.delete();
        got_inst.delete();
        for (int i = 0; i < n; i++) begin
            ce_i = (pc_i <= limit);
            cycle();
            if (id_valid_o === 1'b1) begin
                got_pc.push_back(id_pc_o);
                got_inst.push_back(id_inst_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; inst_gnt = 1'b0;
        pc_i = 32'h0; stray_rvalid = 1'b0;
        cycle();
        cycle();
        vectors++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_id: got valid=%b pc=%h inst=%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
        end
        rst = 1'b0;
        cycle();
        vectors++;
        if (obs_req !== 1'b0 || obs_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req_stall: got req=%b stall=%b want 0/0", obs_req, obs_stall);
        end
    endtask

    task automatic test_basic();
        ce_i = 1'b1; pc_i = 32'hBFC0_0000; inst_gnt = 1'b1; mem_lat = 0; rand_lat = 1'b0;
        cycle();
        vectors++;
        if (obs_addr !== 32'h1FC0_0000) begin
            miscompares++;
            $display("FAIL basic_addr: got %h want 1fc00000", obs_addr);
        end
        vectors++;
        if (obs_req !== 1'b1 || obs_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_grant: got req=%b stall=%b want 1/0", obs_req, obs_stall);
        end
        ce_i = 1'b0;
        cycle();
        cycle();
        vectors++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'hBFC0_0000 || id_inst_o !== 32'h2408_0001) begin
            miscompares++;
            $display("FAIL basic_id: got valid=%b pc=%h inst=%h want 1/bfc00000/24080001",
                     id_valid_o, id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_gnt_delay();
        ce_i = 1'b1; pc_i = 32'h0040_0000; inst_gnt = 1'b0; mem_lat = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (obs_stall !== 1'b1 || obs_addr !== 32'h0040_0000) begin
                miscompares++;
                $display("FAIL gnt_wait_%0d: got stall=%b addr=%h want 1/00400000", i, obs_stall, obs_addr);
            end
        end
        inst_gnt = 1'b1;
        cycle();
        vectors++;
        if (obs_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL gnt_release: got stall=%b want 0", obs_stall);
        end
        collect(5, 32'h0040_0000);
        vectors++;
        if (got_pc.size() != 1 || got_pc[0] !== 32'h0040_0000 || got_inst[0] !== word_of(32'h0040_0000)) begin
            miscompares++;
            $display("FAIL gnt_deliver: got %0d instructions want exactly 1 at 00400000", got_pc.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[3];
        want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8;
        ce_i = 1'b1; pc_i = 32'h0; inst_gnt = 1'b1; stall_i = 1'b1; mem_lat = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i >= 4) begin
                vectors++;
                if (obs_req !== 1'b0 || obs_stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full_backpressure_%0d: got req=%b stall=%b want 0/1", i, obs_req, obs_stall);
                end
            end
        end
        vectors++;
        if (id_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_hold_valid: got %b want 0", id_valid_o);
        end
        stall_i = 1'b0;
        collect(10, 32'h8);
        vectors++;
        if (got_pc.size() != 3) begin
            miscompares++;
            $display("FAIL full_drain_count: got %0d want 3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_pc[i] !== want[i] || got_inst[i] !== word_of(want[i])) begin
                    miscompares++;
                    $display("FAIL full_drain_%0d: got pc=%h inst=%h want %h/%h",
                             i, got_pc[i], got_inst[i], want[i], word_of(want[i]));
                end
            end
        end
    endtask

    task automatic test_flush_wait();
        ce_i = 1'b1; pc_i = 32'h100; inst_gnt = 1'b1; stall_i = 1'b0; mem_lat = 1;
        cycle();
        flush_i = 1'b1; flush_target = 32'h200;
        cycle();
        flush_i = 1'b0; mem_lat = 0;
        vectors++;
        if (id_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wait_valid: got %b want 0", id_valid_o);
        end
        cycle();
        vectors++;
        if (obs_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_discard_req: got %b want 0", obs_req);
        end
        collect(6, 32'h200);
        vectors++;
        if (got_pc.size() != 1 || got_pc[0] !== 32'h200 || got_inst[0] !== word_of(32'h200)) begin
            miscompares++;
            $display("FAIL flush_wait_target: got %0d instructions want exactly 1 at 00000200", got_pc.size());
        end
    endtask

    task automatic test_flush_full();
        ce_i = 1'b1; pc_i = 32'h300; inst_gnt = 1'b1; stall_i = 1'b0; mem_lat = 0;
        cycle();
        stall_i = 1'b1; cycle();
        stall_i = 1'b0; cycle();
        stall_i = 1'b1; cycle();
        cycle();
        flush_i = 1'b1; flush_target = 32'h400;
        cycle();
        flush_i = 1'b0; stall_i = 1'b0;
        vectors++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h300) begin
            miscompares++;
            $display("FAIL flush_full_id: got valid=%b pc=%h want 0/00000300", id_valid_o, id_pc_o);
        end
        collect(1, 32'h400);
        vectors++;
        if (obs_req !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full_idle: got req=%b want 1", obs_req);
        end
        collect(6, 32'h400);
        vectors++;
        if (got_pc.size() != 1 || got_pc[0] !== 32'h400) begin
            miscompares++;
            $display("FAIL flush_full_target: got %0d instructions want exactly 1 at 00000400", got_pc.size());
        end
    endtask

    task automatic test_reset_wait();
        ce_i = 1'b1; pc_i = 32'h500; inst_gnt = 1'b1; mem_lat = 1;
        cycle();
        rst = 1'b1; ce_i = 1'b0;
        cycle();
        rst = 1'b0; stray_rvalid = 1'b1;
        cycle();
        stray_rvalid = 1'b0;
        vectors++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0 ||
            obs_req !== 1'b0 || obs_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_outputs: got valid=%b pc=%h inst=%h req=%b stall=%b want all 0",
                     id_valid_o, id_pc_o, id_inst_o, obs_req, obs_stall);
        end
        cycle();
        cycle();
        vectors++;
        if (id_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_stray: got valid=%b want 0", id_valid_o);
        end
    endtask

    task automatic test_random(int n);
        rand_lat = 1'b1;
        for (int c = 0; c < n; c++) begin
            ce_i         = ($urandom_range(0, 9) != 0);
            flush_i      = ($urandom_range(0, 19) == 0);
            stall_i      = ($urandom_range(0, 9) < 3);
            inst_gnt     = ($urandom_range(0, 2) != 0);
            stray_rvalid = !mem_pending && !m_busy && ($urandom_range(0, 15) == 0);
            flush_target = $urandom & 32'hFFFF_FFFC;
            cycle();
            vectors++;
            if (obs_req !== exp_req) begin
                miscompares++;
                $display("FAIL rand_req cycle %0d: got %b want %b", c, obs_req, exp_req);
            end
            vectors++;
            if (obs_stall !== exp_stall) begin
                miscompares++;
                $display("FAIL rand_stall cycle %0d: got %b want %b", c, obs_stall, exp_stall);
            end
            vectors++;
            if (obs_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL rand_addr cycle %0d: got %h want %h", c, obs_addr, exp_addr);
            end
            vectors++;
            if (id_valid_o !== m_id_valid) begin
                miscompares++;
                $display("FAIL rand_valid cycle %0d: got %b want %b", c, id_valid_o, m_id_valid);
            end
            vectors++;
            if (id_pc_o !== m_id_pc || id_inst_o !== m_id_inst) begin
                miscompares++;
                $display("FAIL rand_id cycle %0d: got pc=%h inst=%h want %h/%h",
                         c, id_pc_o, id_inst_o, m_id_pc, m_id_inst);
            end
        end
        flush_i = 1'b0; stray_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_i = 32'h0; ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gnt_delay();
        test_back_to_back();
        test_flush_wait();
        test_flush_full();
        test_reset_wait();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buf.md
# inst_fetch_buf

Instruction-fetch stage sitting directly downstream of the PC register and upstream of the IF/ID boundary. It takes the current fetch PC and enable, issues a request/grant/valid transaction to instruction memory, and queues returned words with their PCs in a 2-entry buffer. It drives the ID stage with {pc, inst, valid}. It back-pressures the PC register through `stall_o` until each fetch is granted. A branch flush discards queued and in-flight instructions.

## Interface
Parameters:
- `DEPTH`, 2: buffer entries. Only 2 is supported; the pointers are 1 bit.
- `ADDR_MASK_BITS`, 3: number of top address bits cleared on `inst_addr`, giving a kseg-to-physical mapping.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  32  fetch address from the PC register.
- `ce_i`  in  1  fetch enable from the PC register.
- `flush_i`  in  1  branch taken; kill everything younger than the current ID instruction.
- `stall_i`  in  1  ID stage cannot accept a new instruction this cycle.
- `stall_o`  out  1  to the PC register; hold `pc_i` this cycle.
- `inst_req`  out  1  memory request.
- `inst_addr`  out  32  `{3'b000, pc_i[28:0]}`.
- `inst_gnt`  in  1  memory accepts the request this cycle.
- `inst_rvalid`  in  1  read data valid.
- `inst_rdata`  in  32  instruction word.
- `id_pc_o`  out  32  PC of the instruction presented to ID.
- `id_inst_o`  out  32  instruction presented to ID.
- `id_valid_o`  out  1  `id_*` outputs hold a live instruction.

## Operation
FSM states:
- IDLE: no access outstanding.
- WAIT: granted, awaiting `inst_rvalid`.
- DISCARD: flushed while outstanding; the returning word is dropped.

Room condition: `room = (count + (state != IDLE)) < 2`. `count` is the buffer occupancy, 0..2.

Request generation (combinational):
- `inst_req = ce_i & (state==IDLE) & room & ~flush_i`.
- `stall_o = ce_i & ~(inst_req & inst_gnt)`. The PC advances only on a grant.

Transitions:
- IDLE → WAIT on `inst_req & inst_gnt`. Latch `pc_i` into `req_pc`.
- WAIT → IDLE on `inst_rvalid & ~flush_i`. Push `{req_pc, inst_rdata}`.
- WAIT → IDLE on `inst_rvalid & flush_i`. Data is dropped.
- WAIT → DISCARD on `flush_i & ~inst_rvalid`.
- DISCARD → IDLE on `inst_rvalid`. Data is dropped. `flush_i` is ignored in DISCARD.

Buffer and output register:
- When `~stall_i`: `id_valid_o <= (count != 0)`. If `count != 0`, pop the head into `id_pc_o`/`id_inst_o`. If the buffer is empty, `id_pc_o`/`id_inst_o` hold their old values.
- When `stall_i`: all `id_*` outputs hold.
- A push and a pop in the same cycle are both legal. With `count==2`, the pop occurs first and the push is then accepted. A push with `count==2` and no pop cannot occur, because `room` prevents it.

Flush (priority over everything except `rst`):
- Buffer emptied: `count <= 0`, pointers reset.
- `id_valid_o <= 0`, with `id_pc_o`/`id_inst_o` unchanged.
- No push that cycle.
- FSM follows the rules above.

Reset:
- `state=IDLE`, `count=0`, `req_pc=0`.
- `id_pc_o=0`, `id_inst_o=0`, `id_valid_o=0`.
- `inst_req` and `stall_o` follow their combinational definitions; with `ce_i=0` both are 0.
- Reset during WAIT abandons the access. A late `inst_rvalid` arriving in IDLE is ignored.

## Timing
- Request in cycle N with `inst_gnt=1`: the PC advances at edge N.
- `inst_rvalid` in N+1: the word is in the buffer after edge N+1.
- With `stall_i=0`, `id_valid_o=1` after edge N+2. Minimum fetch-to-ID latency is 2 cycles.
- Peak throughput is 1 instruction per 2 cycles. No new request is issued in the cycle the data returns.
- `inst_gnt` may be delayed any number of cycles. `inst_req`/`inst_addr` stay stable while `ce_i` and `pc_i` are stable.
- `inst_rvalid` outside WAIT/DISCARD is ignored.
- Flush takes effect at the same edge; `id_valid_o=0` the next cycle.

## Test plan
- Reset then `ce_i=1`, `pc_i=0xBFC00000`, zero-wait memory returning `0x24080001`:
  - `inst_addr=0x1FC00000`.
  - `stall_o=0` in the grant cycle.
  - Two cycles later `id_pc_o=0xBFC00000`, `id_inst_o=0x24080001`, `id_valid_o=1`.
- `inst_gnt` held low for 3 cycles:
  - `stall_o=1` for those 3 cycles and `inst_addr` is stable.
  - After the grant, exactly one instruction is delivered.
- `stall_i=1` held for 6 cycles while fetching 0x0, 0x4, 0x8:
  - The buffer fills to 2 and `inst_req` drops, so `stall_o=1`.
  - On release, ID sees 0x0, 0x4, 0x8 in order with no loss or duplication.
- `flush_i` in the WAIT cycle, with `inst_rvalid` one cycle later:
  - The FSM enters DISCARD and the word is dropped.
  - `id_valid_o=0`.
  - The next fetch at the branch target is delivered normally.
- `flush_i` coincident with `inst_rvalid` and a full buffer:
  - The buffer is emptied and the data dropped.
  - `id_valid_o=0` next cycle.
  - The FSM is in IDLE.
- `rst` asserted in WAIT, then a stray `inst_rvalid`:
  - All outputs are 0 and nothing is pushed.
